// File: rtl/sccb_pkg.sv
// Types and constants shared by the SCCB arbiter and anything that
// drives or observes it.
package sccb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_RELEASE   = 2'd3
    } arb_state_t;

    localparam logic [7:0] SCCB_DEV_ID_DEFAULT = 8'h42;

    typedef enum logic {
        CAM_FRONT = 1'b0,
        CAM_REAR  = 1'b1
    } cam_sel_t;

endpackage

// File: rtl/sccb_arbiter.sv
// Two-port round-robin arbiter in front of a single SCCB transaction engine
// shared by the front and rear cameras.
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [7:0]  DEV_ID         = SCCB_DEV_ID_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic [7:0]  req0_reg,
    input  logic [7:0]  req0_data,
    input  logic        req0_cam,
    input  logic        req1,
    input  logic [7:0]  req1_reg,
    input  logic [7:0]  req1_data,
    input  logic        req1_cam,
    output logic        ack0,
    output logic        ack1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        eng_start,
    output logic [23:0] eng_indata,
    output logic        eng_cam_sel,
    input  logic        eng_done,
    output logic        busy
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             grant_q, grant_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [23:0]      indata_q, indata_d;
    cam_sel_t         cam_q, cam_d;

    logic             pick;
    logic [1:0]       ack_v;
    logic [1:0]       done_v;
    logic [1:0]       err_v;
    logic             start_v;

    // A lone requester always wins; on a tie the port not served last wins.
    always_comb begin : rr_pick
        if (req0 && req1) begin
            pick = ~last_grant_q;
        end else begin
            pick = req1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        indata_d     = indata_q;
        cam_d        = cam_q;
        ack_v        = 2'b00;
        done_v       = 2'b00;
        err_v        = 2'b00;
        start_v      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant_d     = pick;
                    ack_v[pick] = 1'b1;
                    indata_d    = pick ? {DEV_ID, req1_reg, req1_data}
                                       : {DEV_ID, req0_reg, req0_data};
                    cam_d       = pick ? cam_sel_t'(req1_cam) : cam_sel_t'(req0_cam);
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start_v = 1'b1;
                cnt_d   = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Completion is checked before the timeout so a late done still counts.
                if (eng_done) begin
                    done_v[grant_q] = 1'b1;
                    state_d         = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_v[grant_q] = 1'b1;
                    state_d        = ST_RELEASE;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            cnt_q        <= '0;
            indata_q     <= '0;
            cam_q        <= CAM_FRONT;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            indata_q     <= indata_d;
            cam_q        <= cam_d;
        end
    end

    // Pulses are decoded from the state, so they are masked while reset is
    // held to keep a waiting requester from seeing an ack during reset.
    assign ack0        = ack_v[0]  & ~reset;
    assign ack1        = ack_v[1]  & ~reset;
    assign done0       = done_v[0] & ~reset;
    assign done1       = done_v[1] & ~reset;
    assign err0        = err_v[0]  & ~reset;
    assign err1        = err_v[1]  & ~reset;
    assign eng_start   = start_v   & ~reset;
    assign busy        = (state_q != ST_IDLE) & ~reset;
    assign eng_indata  = indata_q;
    assign eng_cam_sel = cam_q;

endmodule

// File: tb/tb_sccb_arbiter.sv
// Self-checking bench for sccb_arbiter: directed tables, corner sequences
// and a randomized run against a transaction-age reference model.
module tb_sccb_arbiter;

    localparam int T_TO = 16;

    localparam logic [7:0] P_ACK0  = 8'b1000_0000;
    localparam logic [7:0] P_ACK1  = 8'b0100_0000;
    localparam logic [7:0] P_DONE0 = 8'b0010_0000;
    localparam logic [7:0] P_DONE1 = 8'b0001_0000;
    localparam logic [7:0] P_ERR0  = 8'b0000_1000;
    localparam logic [7:0] P_ERR1  = 8'b0000_0100;
    localparam logic [7:0] P_START = 8'b0000_0010;
    localparam logic [7:0] P_BUSY  = 8'b0000_0001;

    typedef struct packed {
        logic [7:0]  pulses;
        logic [23:0] indata;
        logic        cam;
    } obs_t;

    typedef struct {
        logic        r0;
        logic [7:0]  g0;
        logic [7:0]  d0;
        logic        c0;
        logic        r1;
        logic [7:0]  g1;
        logic [7:0]  d1;
        logic        c1;
        logic        ed;
        obs_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, req0_cam, req1_cam, eng_done;
    logic [7:0]  req0_reg, req0_data, req1_reg, req1_data;

    logic        d_ack0, d_ack1, d_done0, d_done1, d_err0, d_err1, d_start, d_busy, d_cam;
    logic [23:0] d_indata;
    logic        t_ack0, t_ack1, t_done0, t_done1, t_err0, t_err1, t_start, t_busy, t_cam;
    logic [23:0] t_indata;
    obs_t        d_obs, t_obs;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sccb_arbiter u_dut_def (
        .clk(clk), .reset(reset),
        .req0(req0), .req0_reg(req0_reg), .req0_data(req0_data), .req0_cam(req0_cam),
        .req1(req1), .req1_reg(req1_reg), .req1_data(req1_data), .req1_cam(req1_cam),
        .ack0(d_ack0), .ack1(d_ack1), .done0(d_done0), .done1(d_done1),
        .err0(d_err0), .err1(d_err1), .eng_start(d_start), .eng_indata(d_indata),
        .eng_cam_sel(d_cam), .eng_done(eng_done), .busy(d_busy)
    );

    sccb_arbiter #(.TIMEOUT_CYCLES(T_TO)) u_dut_t16 (
        .clk(clk), .reset(reset),
        .req0(req0), .req0_reg(req0_reg), .req0_data(req0_data), .req0_cam(req0_cam),
        .req1(req1), .req1_reg(req1_reg), .req1_data(req1_data), .req1_cam(req1_cam),
        .ack0(t_ack0), .ack1(t_ack1), .done0(t_done0), .done1(t_done1),
        .err0(t_err0), .err1(t_err1), .eng_start(t_start), .eng_indata(t_indata),
        .eng_cam_sel(t_cam), .eng_done(eng_done), .busy(t_busy)
    );

    assign d_obs = {d_ack0, d_ack1, d_done0, d_done1, d_err0, d_err1, d_start, d_busy, d_indata, d_cam};
    assign t_obs = {t_ack0, t_ack1, t_done0, t_done1, t_err0, t_err1, t_start, t_busy, t_indata, t_cam};

    function automatic obs_t ob(input logic [7:0] pl, input logic [23:0] ind, input logic cm);
        obs_t o;
        o.pulses = pl;
        o.indata = ind;
        o.cam    = cm;
        return o;
    endfunction

    function automatic vec_t mkv(input logic r0, input logic [7:0] g0, input logic [7:0] d0,
                                 input logic c0, input logic r1, input logic [7:0] g1,
                                 input logic [7:0] d1, input logic c1, input logic ed,
                                 input logic [7:0] pl, input logic [23:0] ind, input logic cm);
        vec_t v;
        v.r0 = r0; v.g0 = g0; v.d0 = d0; v.c0 = c0;
        v.r1 = r1; v.g1 = g1; v.d1 = d1; v.c1 = c1;
        v.ed = ed;
        v.exp = ob(pl, ind, cm);
        return v;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got pulses(ack0,ack1,done0,done1,err0,err1,start,busy)=%b indata=%h cam=%b, want pulses=%b indata=%h cam=%b",
                     name, $time, act.pulses, act.indata, act.cam, exp.pulses, exp.indata, exp.cam);
        end
    endtask

    task automatic end_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 1'b0; req0_reg = 8'h00; req0_data = 8'h00; req0_cam = 1'b0;
        req1 = 1'b0; req1_reg = 8'h00; req1_data = 8'h00; req1_cam = 1'b0;
        eng_done = 1'b0;
    endtask

    // Leaves the bench one step after a rising edge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        check("reset_state_t16", t_obs, obs_t'(0));
        check("reset_state_def", d_obs, obs_t'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // One transaction on port 1; done_at < 0 means the engine never answers.
    task automatic single_case(input string name, input int done_at, input bit with_req0);
        obs_t e;
        bit   ok_done;
        int   fin;
        ok_done = (done_at >= 2 && done_at <= T_TO + 1);
        fin     = ok_done ? done_at : T_TO + 1;
        for (int c = 0; c <= fin + 4; c++) begin
            req1 = (c == 0); req1_reg = 8'h55; req1_data = 8'h66; req1_cam = 1'b1;
            req0 = with_req0 && (c >= 5) && (c <= fin + 2);
            req0_reg = 8'h77; req0_data = 8'h88; req0_cam = 1'b0;
            eng_done = (c == done_at);
            @(negedge clk);
            e = ob(8'h00, 24'h425566, 1'b1);
            if (c == 0) e = ob(P_ACK1, 24'h0, 1'b0);
            if (c == 1) e.pulses = P_START;
            if (c == fin) e.pulses = ok_done ? P_DONE1 : P_ERR1;
            if (with_req0 && c == fin + 2) e.pulses = P_ACK0;
            if (with_req0 && c == fin + 3) e.pulses = P_START;
            if (with_req0 && c >= fin + 3) begin
                e.indata = 24'h427788;
                e.cam    = 1'b0;
            end
            if ((c >= 1 && c <= fin + 1) || (with_req0 && c >= fin + 3)) e.pulses = e.pulses | P_BUSY;
            check(name, t_obs, e);
            end_cycle();
        end
        $display("[TB] %s: transaction on port 1 finished", name);
    endtask

    // Reference model: tracks the age of the current transaction in cycles
    // since its grant and applies the arbiter rules directly.
    bit          m_active;
    bit          m_win;
    bit          m_last;
    bit          m_err;
    int          m_age;
    int          m_end;
    logic [23:0] m_indata;
    logic        m_cam;

    task automatic model_reset();
        m_active = 1'b0; m_win = 1'b0; m_last = 1'b1; m_err = 1'b0;
        m_age = 0; m_end = -1; m_indata = 24'h0; m_cam = 1'b0;
    endtask

    task automatic model_step(output obs_t e);
        e = ob(8'h00, m_indata, m_cam);
        if (!m_active) begin
            if (req0 || req1) begin
                m_win    = (req0 && req1) ? ~m_last : req1;
                e.pulses = m_win ? P_ACK1 : P_ACK0;
                m_active = 1'b1;
                m_age    = 0;
                m_end    = -1;
                m_indata = m_win ? {8'h42, req1_reg, req1_data} : {8'h42, req0_reg, req0_data};
                m_cam    = m_win ? req1_cam : req0_cam;
            end
        end else begin
            m_age++;
            e.pulses = P_BUSY;
            if (m_age == 1) begin
                e.pulses = e.pulses | P_START;
            end else if (m_end < 0) begin
                if (eng_done) begin
                    e.pulses = e.pulses | (m_win ? P_DONE1 : P_DONE0);
                    m_end = m_age;
                    m_err = 1'b0;
                end else if (m_age == T_TO + 1) begin
                    e.pulses = e.pulses | (m_win ? P_ERR1 : P_ERR0);
                    m_end = m_age;
                    m_err = 1'b1;
                end
            end else begin
                m_last   = m_win;
                m_active = 1'b0;
                $display("[TB] random txn: port %0d indata %h cam %0d %s after %0d cycles",
                         m_win, m_indata, m_cam, m_err ? "timed out" : "completed", m_end);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[16];
        obs_t e;
        int   p, ph;
        bit   prev_ack0, prev_ack1;

        clear_inputs();
        reset = 1'b1;

        // Directed table: spurious eng_done, min turnaround, tie arbitration.
        vt[0]  = mkv(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 8'h00,            24'h000000, 0);
        vt[1]  = mkv(0, 8'h00, 8'h00, 0, 1, 8'hAB, 8'hCD, 1, 0, P_ACK1,           24'h000000, 0);
        vt[2]  = mkv(0, 8'h00, 8'h00, 0, 0, 8'hAB, 8'hCD, 1, 1, P_START | P_BUSY, 24'h42ABCD, 1);
        vt[3]  = mkv(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, P_DONE1 | P_BUSY, 24'h42ABCD, 1);
        vt[4]  = mkv(1, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 0, 1, P_BUSY,           24'h42ABCD, 1);
        vt[5]  = mkv(1, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 0, 0, P_ACK0,           24'h42ABCD, 1);
        vt[6]  = mkv(0, 8'h12, 8'h34, 0, 0, 8'h00, 8'h00, 0, 0, P_START | P_BUSY, 24'h421234, 0);
        vt[7]  = mkv(0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, P_DONE0 | P_BUSY, 24'h421234, 0);
        vt[8]  = mkv(1, 8'h01, 8'h02, 0, 1, 8'h03, 8'h04, 1, 0, P_BUSY,           24'h421234, 0);
        vt[9]  = mkv(1, 8'h01, 8'h02, 0, 1, 8'h03, 8'h04, 1, 0, P_ACK1,           24'h421234, 0);
        vt[10] = mkv(1, 8'h01, 8'h02, 0, 0, 8'h03, 8'h04, 1, 0, P_START | P_BUSY, 24'h420304, 1);
        vt[11] = mkv(1, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, P_BUSY,           24'h420304, 1);
        vt[12] = mkv(1, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0, 1, P_DONE1 | P_BUSY, 24'h420304, 1);
        vt[13] = mkv(1, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, P_BUSY,           24'h420304, 1);
        vt[14] = mkv(1, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, P_ACK0,           24'h420304, 1);
        vt[15] = mkv(0, 8'h01, 8'h02, 0, 0, 8'h00, 8'h00, 0, 0, P_START | P_BUSY, 24'h420102, 0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            req0 = vt[i].r0; req0_reg = vt[i].g0; req0_data = vt[i].d0; req0_cam = vt[i].c0;
            req1 = vt[i].r1; req1_reg = vt[i].g1; req1_data = vt[i].d1; req1_cam = vt[i].c1;
            eng_done = vt[i].ed;
            @(negedge clk);
            check($sformatf("table[%0d]", i), t_obs, vt[i].exp);
            end_cycle();
        end
        $display("[TB] directed table: 4 transactions applied");

        // Single req0 on the default-timeout instance, done in cycle 20.
        clear_inputs();
        do_reset();
        for (int c = 0; c <= 22; c++) begin
            req0 = (c == 0); req0_reg = 8'h12; req0_data = 8'h80; req0_cam = 1'b0;
            eng_done = (c == 20);
            @(negedge clk);
            e = ob(8'h00, (c == 0) ? 24'h0 : 24'h421280, 1'b0);
            if (c == 0)  e.pulses = P_ACK0;
            if (c == 1)  e.pulses = P_START;
            if (c == 20) e.pulses = P_DONE0;
            if (c >= 1 && c <= 21) e.pulses = e.pulses | P_BUSY;
            check("single_req0", d_obs, e);
            end_cycle();
        end
        $display("[TB] single_req0: transaction on port 0 finished");

        // Both requests held from reset: grants alternate, cam follows the port.
        clear_inputs();
        req0 = 1'b1; req0_reg = 8'h10; req0_data = 8'h00; req0_cam = 1'b0;
        req1 = 1'b1; req1_reg = 8'h11; req1_data = 8'h01; req1_cam = 1'b1;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            p  = (c / 4) % 2;
            ph = c % 4;
            eng_done = (ph == 2);
            @(negedge clk);
            if (c == 0) begin
                e = ob(8'h00, 24'h0, 1'b0);
            end else if (ph == 0) begin
                e = ob(8'h00, (p == 1) ? 24'h421000 : 24'h421101, (p == 1) ? 1'b0 : 1'b1);
            end else begin
                e = ob(8'h00, (p == 1) ? 24'h421101 : 24'h421000, (p == 1) ? 1'b1 : 1'b0);
            end
            case (ph)
                0: e.pulses = (p == 1) ? P_ACK1 : P_ACK0;
                1: e.pulses = P_START | P_BUSY;
                2: e.pulses = ((p == 1) ? P_DONE1 : P_DONE0) | P_BUSY;
                default: e.pulses = P_BUSY;
            endcase
            check("round_robin", t_obs, e);
            end_cycle();
        end
        $display("[TB] round_robin: 4 alternating transactions finished");

        // Timeout with a pending req0, then done coinciding with the timeout.
        clear_inputs();
        do_reset();
        single_case("timeout_err", -1, 1'b1);
        clear_inputs();
        do_reset();
        single_case("done_at_timeout", T_TO + 1, 1'b0);

        // Asynchronous reset in the middle of WAIT_DONE with req1 held.
        clear_inputs();
        do_reset();
        req1 = 1'b1; req1_reg = 8'h9A; req1_data = 8'hBC; req1_cam = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            e = ob(8'h00, (c == 0) ? 24'h0 : 24'h429ABC, (c == 0) ? 1'b0 : 1'b1);
            if (c == 0) e.pulses = P_ACK1;
            if (c == 1) e.pulses = P_START | P_BUSY;
            if (c >= 2) e.pulses = P_BUSY;
            check("pre_reset", t_obs, e);
            if (c < 5) end_cycle();
        end
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_t16", t_obs, obs_t'(0));
        check("async_reset_def", d_obs, obs_t'(0));
        @(negedge clk);
        check("reset_held", t_obs, obs_t'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            req1 = (c == 0);
            @(negedge clk);
            e = ob(8'h00, (c == 0) ? 24'h0 : 24'h429ABC, (c == 0) ? 1'b0 : 1'b1);
            if (c == 0) e.pulses = P_ACK1;
            if (c == 1) e.pulses = P_START | P_BUSY;
            if (c >= 2) e.pulses = P_BUSY;
            check("post_reset_regrant", t_obs, e);
            end_cycle();
        end
        $display("[TB] reset_abort: port 1 re-granted once after reset");

        // Randomized traffic against the reference model.
        clear_inputs();
        do_reset();
        model_reset();
        prev_ack0 = 1'b0;
        prev_ack1 = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            if (prev_ack0) begin
                if ($urandom_range(0, 1) == 0) req0 = 1'b0;
                else begin
                    req0_reg = 8'($urandom); req0_data = 8'($urandom); req0_cam = 1'($urandom);
                end
            end
            if (prev_ack1) begin
                if ($urandom_range(0, 1) == 0) req1 = 1'b0;
                else begin
                    req1_reg = 8'($urandom); req1_data = 8'($urandom); req1_cam = 1'($urandom);
                end
            end
            if (!req0 && $urandom_range(0, 2) == 0) begin
                req0 = 1'b1; req0_reg = 8'($urandom); req0_data = 8'($urandom); req0_cam = 1'($urandom);
            end
            if (!req1 && $urandom_range(0, 2) == 0) begin
                req1 = 1'b1; req1_reg = 8'($urandom); req1_data = 8'($urandom); req1_cam = 1'($urandom);
            end
            eng_done = ($urandom_range(0, 11) == 0);
            model_step(e);
            @(negedge clk);
            check("random", t_obs, e);
            prev_ack0 = (e.pulses & P_ACK0) != 8'h00;
            prev_ack1 = (e.pulses & P_ACK1) != 8'h00;
            end_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sccb_arbiter.md
SCCB_ARBITER -- requirements
Module: sccb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: max cycles WAIT_DONE waits for eng_done before abort.
REQ-002 Parameter DEV_ID, default 8'h42: SCCB write ID, placed in eng_indata[23:16].
REQ-003 clk  in  1  SCCB tick clock, the same clock that drives the transaction engine.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 req0 / req1  in  1  transaction request; 0 = ROM init sequencer, 1 = runtime register writer.
REQ-006 req0_reg / req1_reg  in  8  target register address.
REQ-007 req0_data / req1_data  in  8  write data.
REQ-008 req0_cam / req1_cam  in  1  target camera (0 = front, 1 = rear).
REQ-009 ack0 / ack1  out  1  one-cycle pulse: payload latched, requester may drop req.
REQ-010 done0 / done1  out  1  one-cycle pulse: transaction completed on the bus.
REQ-011 err0 / err1  out  1  one-cycle pulse instead of done: transaction timed out.
REQ-012 eng_start  out  1  one-cycle start pulse to the SCCB engine.
REQ-013 eng_indata  out  24  {DEV_ID, reg, data} to the engine.
REQ-014 eng_cam_sel  out  1  SCL/SDA mux select, stable from latch until release.
REQ-015 eng_done  in  1  engine completion pulse.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT_DONE, RELEASE.
REQ-018 IDLE, no req asserted: stay in IDLE.
REQ-019 IDLE, any req asserted: pick a winner, latch its reg/data/cam into eng_indata/eng_cam_sel, pulse ackN in the same cycle, go to ISSUE.
REQ-020 Arbitration is round-robin: a 1-bit last_grant register; on a simultaneous req, grant the requester not equal to last_grant; last_grant resets to 1, so port 0 wins the first tie.
REQ-021 ISSUE: assert eng_start for exactly one cycle, clear the timeout counter, go to WAIT_DONE.
REQ-022 WAIT_DONE: on eng_done, pulse doneN for the granted port and go to RELEASE.
REQ-023 WAIT_DONE: counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 without eng_done, pulse errN and go to RELEASE.
REQ-024 If eng_done and the timeout occur in the same cycle, done wins; no err pulse.
REQ-025 eng_done seen in IDLE, ISSUE or RELEASE is ignored.
REQ-026 RELEASE: hold eng_cam_sel for one cycle (bus settle), update last_grant to the served port, go to IDLE.
REQ-027 Minimum turnaround is 4 cycles, ack to next possible ack.
REQ-028 A req still high in IDLE after its done is treated as a new request.
REQ-029 A requester must hold req and payload stable until ack; a req dropped before ack is never granted.
REQ-030 eng_indata and eng_cam_sel change only in IDLE on a grant.
REQ-031 Timeout counter width is $clog2(TIMEOUT_CYCLES)+1; it saturates and never wraps.
REQ-032 At most one of ack0/ack1, done0/done1, err0/err1 is high in any cycle.

Reset
REQ-033 reset asynchronously forces: state IDLE, last_grant 1, counter 0, eng_indata 0, eng_cam_sel 0, all ack/done/err/eng_start/busy 0.
REQ-034 Reset mid-transaction aborts silently: no done or err pulse; eng_start stays low until the next grant.

Structure
REQ-035 The shared package sccb_pkg holds the state enum, default DEV_ID (8'h42) and the camera-select encoding.
REQ-036 The FSM is a single module with no sub-modules; the round-robin picker is an always_comb block inside it.

Verification
REQ-037 Single req0 (reg 8'h12, data 8'h80, cam 0): ack0 in cycle 0, eng_start in cycle 1 with eng_indata 24'h421280, eng_done in cycle 20 -> done0 in cycle 20, busy low in cycle 22.
REQ-038 req0 and req1 both held high from reset: grants alternate 0,1,0,1 over four transactions, and eng_cam_sel follows each reqN_cam.
REQ-039 TIMEOUT_CYCLES=16, eng_done never asserted: err1 pulses 16 cycles after eng_start, no done1, arbiter then serves a pending req0.
REQ-040 eng_done and the timeout in the same cycle -> done only. Spurious eng_done in IDLE -> no output pulse.
REQ-041 reset asserted in WAIT_DONE: all outputs 0 immediately (asynchronous); after release, a held req1 is granted once with correct payload.
